gold_seq_ctrl: RTL and testbench

//  Sequences the x1/x2 LFSR generators that produce the 38.211 gold sequence c(n) (Nc=1600 jump-ahead inside the generators).

---
 rtl/gold_seq_ctrl_if.sv | 41 ++++
 rtl/gold_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_gold_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gold_seq_ctrl_if.sv
// gold_seq_ctrl_if
//   Bundles every signal of gold_seq_ctrl except clk/rst: the request channel,
//   the control/data path to the shared x1/x2 generator pair, and the output
//   word stream.
//   master : view of the sequencer itself (gold_seq_ctrl)
//   slave  : view of the surroundings (requester, generators, consumer)
//   Request : i_req_valid, o_req_ready, i_c_init[30:0], i_len[LEN_W-1:0], i_abort
//   Gen     : o_gen_load, o_x2_init[30:0], o_gen_en, i_x1_bits, i_x2_bits
//   Stream  : o_valid, i_ready, o_data[NGENBIT-1:0], o_nbits, o_last
interface gold_seq_ctrl_if #(
  parameter int NGENBIT = 8,
  parameter int LEN_W   = 16
);
  localparam int NB_W = $clog2(NGENBIT + 1);

  logic               i_req_valid;
  logic               o_req_ready;
  logic [30:0]        i_c_init;
  logic [LEN_W-1:0]   i_len;
  logic               i_abort;
  logic               o_gen_load;
  logic [30:0]        o_x2_init;
  logic               o_gen_en;
  logic [NGENBIT-1:0] i_x1_bits;
  logic [NGENBIT-1:0] i_x2_bits;
  logic               o_valid;
  logic               i_ready;
  logic [NGENBIT-1:0] o_data;
  logic [NB_W-1:0]    o_nbits;
  logic               o_last;

  modport master (
    input  i_req_valid, i_c_init, i_len, i_abort, i_x1_bits, i_x2_bits, i_ready,
    output o_req_ready, o_gen_load, o_x2_init, o_gen_en, o_valid, o_data, o_nbits, o_last
  );

  modport slave (
    output i_req_valid, i_c_init, i_len, i_abort, i_x1_bits, i_x2_bits, i_ready,
    input  o_req_ready, o_gen_load, o_x2_init, o_gen_en, o_valid, o_data, o_nbits, o_last
  );
endinterface

// File: rtl/gold_seq_ctrl.sv
// gold_seq_ctrl
//   Sequencer for the shared x1/x2 LFSR generators that produce the gold
//   sequence c(n). Takes one request {c_init, length in bits}, pulses a load
//   into both generators, then steps them one word at a time under downstream
//   backpressure and streams c(n) = x1 ^ x2 as masked words with a valid-bit
//   count and a last flag.
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : gold_seq_ctrl_if.master (request, generator control, output stream)
module gold_seq_ctrl #(
  parameter int NGENBIT = 8,
  parameter int LEN_W   = 16
) (
  input logic            clk,
  input logic            rst,
  gold_seq_ctrl_if.master bus
);
  localparam int NB_W = $clog2(NGENBIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [30:0]        cInit_q, cInit_d;
  logic [LEN_W-1:0]   remWords_q, remWords_d;
  logic [NB_W-1:0]    tail_q, tail_d;
  logic               valid_q, valid_d;
  logic               lastWord_q, lastWord_d;

  logic               genEn;
  logic [LEN_W-1:0]   reqWords;
  logic [LEN_W-1:0]   reqRem;
  logic [NB_W-1:0]    reqTail;
  logic [NB_W-1:0]    curNbits;
  logic [NGENBIT-1:0] allOnes;
  logic [NGENBIT-1:0] wordMask;

  // Word count and tail size of the incoming request. Using quotient plus a
  // remainder test (rather than (len+N-1)/N) keeps the arithmetic inside
  // LEN_W bits even for the largest length.
  always_comb begin
    reqWords = bus.i_len / LEN_W'(NGENBIT);
    reqRem   = bus.i_len % LEN_W'(NGENBIT);
    reqTail  = NB_W'(NGENBIT);
    if (reqRem != '0) begin
      reqWords = reqWords + LEN_W'(1);
      reqTail  = NB_W'(reqRem);
    end
  end

  // A generator step happens only when the output slot is free or being
  // consumed this cycle, so the generator registers (and o_data) hold still
  // while downstream stalls. An abort suppresses the step.
  always_comb begin
    genEn = (state_q == RUN) && (!valid_q || bus.i_ready) && !bus.i_abort;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cInit_q    <= '0;
      remWords_q <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b0;
      lastWord_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cInit_q    <= cInit_d;
      remWords_q <= remWords_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      lastWord_q <= lastWord_d;
    end
  end

  // Next-state logic. The final step moves to DRAIN so that no further
  // generator steps occur while the last word waits for acceptance.
  always_comb begin
    state_d    = state_q;
    cInit_d    = cInit_q;
    remWords_d = remWords_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    lastWord_d = lastWord_q;

    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          cInit_d    = bus.i_c_init;
          remWords_d = reqWords;
          tail_d     = reqTail;
          lastWord_d = 1'b0;
          // A zero-length request is consumed without touching the generators.
          if (bus.i_len != '0) begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (genEn) begin
          valid_d    = 1'b1;
          remWords_d = remWords_q - LEN_W'(1);
          if (remWords_q == LEN_W'(1)) begin
            lastWord_d = 1'b1;
            state_d    = DRAIN;
          end
        end else if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (valid_q && bus.i_ready) begin
          valid_d    = 1'b0;
          lastWord_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a final handshake in the same cycle.
    if (bus.i_abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      lastWord_d = 1'b0;
    end
  end

  // Output word: generator XOR, with bits above the valid count forced to
  // zero. An empty slot reports zero bits, which also zeroes o_data.
  always_comb begin
    allOnes = '1;
    if (!valid_q) begin
      curNbits = '0;
    end else if (lastWord_q) begin
      curNbits = tail_q;
    end else begin
      curNbits = NB_W'(NGENBIT);
    end
    wordMask = ~(allOnes << curNbits);
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_gen_load  = (state_q == LOAD);
  assign bus.o_x2_init   = cInit_q;
  assign bus.o_gen_en    = genEn;
  assign bus.o_valid     = valid_q;
  assign bus.o_last      = valid_q && lastWord_q;
  assign bus.o_nbits     = curNbits;
  assign bus.o_data      = (bus.i_x1_bits ^ bus.i_x2_bits) & wordMask;

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// tb_gold_seq_ctrl
//   Bench for gold_seq_ctrl with NGENBIT=8. A behavioural x1/x2 generator
//   pair reacts to o_gen_load/o_gen_en; expected words are computed from an
//   independent c(n) reference and queued when each request is driven, then
//   popped as the DUT hands words over.
module tb_gold_seq_ctrl;
  localparam int NGENBIT = 8;
  localparam int LEN_W   = 16;
  localparam int NB_W    = $clog2(NGENBIT + 1);
  localparam int NC      = 1600;

  typedef struct {
    logic [NGENBIT-1:0] data;
    logic [NB_W-1:0]    nbits;
    logic               last;
  } word_t;

  typedef struct {
    logic [30:0] cInit;
    int          len;
    bit          randomReady;
    int          expWords;
    int          expTail;
  } vec_t;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  int   wordsSeen;
  bit   readyRandom;
  word_t scoreQ[$];

  logic [NGENBIT-1:0] x1Reg, x2Reg;
  logic [30:0]        genInit;
  int                 genIdx;

  gold_seq_ctrl_if #(.NGENBIT(NGENBIT), .LEN_W(LEN_W)) bus ();

  gold_seq_ctrl #(.NGENBIT(NGENBIT), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x(idx) of an LFSR seeded with init; isX2 selects the x2 polynomial.
  function automatic logic lfsrBit(input logic [30:0] init, input bit isX2, input int idx);
    logic [30:0] s;
    logic nb;
    s = init;
    for (int k = 0; k < idx; k++) begin
      nb = isX2 ? (s[0] ^ s[1] ^ s[2] ^ s[3]) : (s[0] ^ s[3]);
      s  = {nb, s[30:1]};
    end
    return s[0];
  endfunction

  function automatic logic [NGENBIT-1:0] genWord(input logic [30:0] init, input bit isX2, input int start);
    logic [NGENBIT-1:0] w;
    w = '0;
    for (int b = 0; b < NGENBIT; b++) w[b] = lfsrBit(init, isX2, start + b);
    return w;
  endfunction

  function automatic logic goldenC(input logic [30:0] cInit, input int n);
    return lfsrBit(31'd1, 1'b0, n + NC) ^ lfsrBit(cInit, 1'b1, n + NC);
  endfunction

  function automatic logic [NGENBIT-1:0] expData(input logic [30:0] cInit, input int wIdx, input int nb);
    logic [NGENBIT-1:0] d;
    d = '0;
    for (int b = 0; b < NGENBIT; b++) if (b < nb) d[b] = goldenC(cInit, wIdx * NGENBIT + b);
    return d;
  endfunction

  // Behavioural generator pair: load restarts at n=0, each step presents the
  // next NGENBIT bits of the jumped-ahead sequences.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      x1Reg   <= '0;
      x2Reg   <= '0;
      genInit <= '0;
      genIdx  <= 0;
    end else if (bus.o_gen_load) begin
      genInit <= bus.o_x2_init;
      genIdx  <= 0;
    end else if (bus.o_gen_en) begin
      x1Reg  <= genWord(31'd1, 1'b0, genIdx + NC);
      x2Reg  <= genWord(genInit, 1'b1, genIdx + NC);
      genIdx <= genIdx + NGENBIT;
    end
  end
  assign bus.i_x1_bits = x1Reg;
  assign bus.i_x2_bits = x2Reg;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always high, or a fair coin each cycle.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on each handshake, hold check while stalled.
  initial begin : monitor
    bit prevStall;
    logic [NGENBIT-1:0] heldData;
    word_t w;
    prevStall = 1'b0;
    heldData  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall && bus.o_valid) checkOutput("stall_hold", 64'(bus.o_data), 64'(heldData));
        if (bus.o_valid && !bus.i_ready) checkOutput("en_while_stalled", 64'(bus.o_gen_en), 64'd0);
        if (bus.o_valid && bus.i_ready && !bus.i_abort) begin
          if (scoreQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", bus.o_data);
          end else begin
            w = scoreQ.pop_front();
            checkOutput("word_data", 64'(bus.o_data), 64'(w.data));
            checkOutput("word_nbits", 64'(bus.o_nbits), 64'(w.nbits));
            checkOutput("word_last", 64'(bus.o_last), 64'(w.last));
            wordsSeen++;
          end
        end
        prevStall = bus.o_valid && !bus.i_ready;
        heldData  = bus.o_data;
      end
    end
  end

  task automatic applyStimulus(input logic [30:0] cInit, input int len);
    int n;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b1;
    bus.i_c_init    = cInit;
    bus.i_len       = LEN_W'(len);
    n = 0;
    @(negedge clk);
    while (!bus.o_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_accept", 64'(bus.o_req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    if (len != 0) begin
      @(negedge clk);
      checkOutput("load_pulse", 64'(bus.o_gen_load), 64'd1);
      checkOutput("x2_init", 64'(bus.o_x2_init), 64'(cInit));
      @(negedge clk);
      checkOutput("first_en", 64'({bus.o_gen_en, bus.o_valid}), 64'b10);
      @(negedge clk);
      checkOutput("first_valid", 64'(bus.o_valid), 64'd1);
    end
  endtask

  task automatic pushExpected(input logic [30:0] cInit, input int words, input int tail);
    word_t w;
    for (int i = 0; i < words; i++) begin
      w.last  = (i == words - 1);
      w.nbits = NB_W'(w.last ? tail : NGENBIT);
      w.data  = expData(cInit, i, int'(w.nbits));
      scoreQ.push_back(w);
    end
  endtask

  task automatic runReq(input logic [30:0] cInit, input int len, input bit rnd, input int words, input int tail);
    int base;
    int n;
    readyRandom = rnd;
    base = wordsSeen;
    pushExpected(cInit, words, tail);
    applyStimulus(cInit, len);
    n = 0;
    while ((scoreQ.size() != 0 || !bus.o_req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 64'(scoreQ.size()), 64'd0);
    checkOutput("word_count", 64'(wordsSeen - base), 64'(words));
    readyRandom = 1'b0;
  endtask

  task automatic waitWords(input int target);
    int n;
    n = 0;
    while (wordsSeen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_words", 64'(wordsSeen >= target), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs[6];
    bit sawActivity;
    int base;

    vecs[0] = '{31'h12345,    20, 1'b0, 3, 4};
    vecs[1] = '{31'h12345,    20, 1'b1, 3, 4};
    vecs[2] = '{31'h1,         1, 1'b0, 1, 1};
    vecs[3] = '{31'h5A5A,     16, 1'b0, 2, 8};
    vecs[4] = '{31'h7FFFFFFF,  9, 1'b0, 2, 1};
    vecs[5] = '{31'h2AAAAAA,  25, 1'b1, 4, 1};

    assertCount     = 0;
    failCount       = 0;
    wordsSeen       = 0;
    readyRandom     = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.i_c_init    = '0;
    bus.i_len       = '0;
    bus.i_abort     = 1'b0;
    rst             = 1'b1;

    // Reset state
    #23;
    checkOutput("rst_outputs", 64'({bus.o_valid, bus.o_gen_load, bus.o_gen_en, bus.o_last}), 64'd0);
    checkOutput("rst_x2_init", 64'(bus.o_x2_init), 64'd0);
    checkOutput("rst_data", 64'(bus.o_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 64'(bus.o_req_ready), 64'd1);

    // Table-driven requests, issued back to back
    for (int i = 0; i < 6; i++) begin
      runReq(vecs[i].cInit, vecs[i].len, vecs[i].randomReady, vecs[i].expWords, vecs[i].expTail);
    end

    // Zero-length request: consumed with no load and no output
    applyStimulus(31'h12345, 0);
    sawActivity = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sawActivity |= bus.o_gen_load | bus.o_valid | bus.o_gen_en;
    end
    checkOutput("len0_no_activity", 64'(sawActivity), 64'd0);
    checkOutput("len0_idle", 64'(bus.o_req_ready), 64'd1);

    // Abort part-way through a 64-bit request
    base = wordsSeen;
    pushExpected(31'h3C3C3C, 8, 8);
    applyStimulus(31'h3C3C3C, 64);
    waitWords(base + 3);
    @(posedge clk);
    #1;
    bus.i_abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_en", 64'(bus.o_gen_en), 64'd0);
    @(posedge clk);
    #1;
    bus.i_abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid_low", 64'(bus.o_valid), 64'd0);
    checkOutput("abort_idle", 64'(bus.o_req_ready), 64'd1);
    scoreQ.delete();
    runReq(31'h1, 20, 1'b0, 3, 4);

    // Reset in the middle of a run
    base = wordsSeen;
    pushExpected(31'h777, 13, 4);
    applyStimulus(31'h777, 100);
    waitWords(base + 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_outputs", 64'({bus.o_valid, bus.o_gen_load, bus.o_gen_en, bus.o_last}), 64'd0);
    checkOutput("midrst_data", 64'(bus.o_data), 64'd0);
    checkOutput("midrst_x2_init", 64'(bus.o_x2_init), 64'd0);
    scoreQ.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 64'(bus.o_req_ready), 64'd1);
    runReq(31'h12345, 20, 1'b0, 3, 4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
